// File: rtl/cm_pack.sv
// Saber ciphertext cm stage: rounds each v' coefficient against its message bit
// to 4 bits and packs sixteen 4-bit results into each 64-bit output word.
module cm_pack #(
    parameter logic [9:0] H1          = 10'd4,
    parameter int         NUM_V_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        read_base_sel,
    output logic [8:0]  read_address,
    input  logic [63:0] read_data,
    output logic [8:0]  write_address,
    output logic [63:0] write_data,
    output logic        write_en,
    output logic        done
);

    localparam logic [6:0] LAST_V_IDX = 7'(NUM_V_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_M_ADDR,
        S_M_LOAD,
        S_V_ADDR,
        S_V_LOAD,
        S_CALC,
        S_STORE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [6:0]  v_idx;
    logic [63:0] m_buf;
    logic [63:0] v_buf;
    logic [63:0] cm_buf;
    logic [8:0]  wr_addr;

    // t = v + h1 - (m << 9) wraps in 10 bits; the top nibble is the rounded value.
    function automatic logic [3:0] lane_cm(input logic [9:0] v, input logic m);
        logic [9:0] t;
        t = v + H1 - {m, 9'd0};
        return t[9:6];
    endfunction

    // Memory read port: the address is held for the *_ADDR cycle and the
    // following *_LOAD cycle, where the one-cycle-latency data is captured.
    always_comb begin
        state_n       = state;
        read_base_sel = 1'b0;
        read_address  = '0;
        write_en      = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_M_ADDR;
            end
            S_M_ADDR: begin
                read_base_sel = 1'b1;
                read_address  = {7'd0, v_idx[5:4]};
                state_n       = S_M_LOAD;
            end
            S_M_LOAD: begin
                read_base_sel = 1'b1;
                read_address  = {7'd0, v_idx[5:4]};
                state_n       = S_V_ADDR;
            end
            S_V_ADDR: begin
                read_address = {3'd0, v_idx[5:0]};
                state_n      = S_V_LOAD;
            end
            S_V_LOAD: begin
                read_address = {3'd0, v_idx[5:0]};
                state_n      = S_CALC;
            end
            S_CALC: begin
                if (v_idx[1:0] == 2'd0) state_n = S_STORE;
                else                    state_n = S_V_ADDR;
            end
            S_STORE: begin
                write_en = 1'b1;
                if (v_idx == LAST_V_IDX)     state_n = S_DONE;
                else if (v_idx[3:0] == 4'd0) state_n = S_M_ADDR;
                else                         state_n = S_V_ADDR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_n = S_M_ADDR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            v_idx   <= '0;
            m_buf   <= '0;
            v_buf   <= '0;
            cm_buf  <= '0;
            wr_addr <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        v_idx   <= '0;
                        wr_addr <= '0;
                    end
                end
                S_M_LOAD: m_buf <= read_data;
                S_V_LOAD: begin
                    v_buf <= read_data;
                    v_idx <= v_idx + 7'd1;
                end
                S_CALC: begin
                    // Four new nibbles enter at the top so word k ends up with coefficient 16k in bits [3:0].
                    cm_buf <= {lane_cm(v_buf[57:48], m_buf[3]),
                               lane_cm(v_buf[41:32], m_buf[2]),
                               lane_cm(v_buf[25:16], m_buf[1]),
                               lane_cm(v_buf[9:0],   m_buf[0]),
                               cm_buf[63:16]};
                    m_buf  <= m_buf >> 4;
                end
                S_STORE: wr_addr <= wr_addr + 9'd1;
                default: ;
            endcase
        end
    end

    assign write_address = wr_addr;
    assign write_data    = cm_buf;

endmodule

// File: tb/tb_cm_pack.sv
// Bench for cm_pack: memory model, directed pattern passes, random pass against
// a coefficient-level reference, busy-start, rerun from DONE and mid-pass reset.
module tb_cm_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        read_base_sel;
    logic [8:0]  read_address;
    logic [63:0] read_data;
    logic [8:0]  write_address;
    logic [63:0] write_data;
    logic        write_en;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] mem_v [0:63];
    logic [63:0] mem_m [0:3];
    logic [63:0] exp_q [$];

    logic        tr_sel  [0:299];
    logic [8:0]  tr_ra   [0:299];
    logic        tr_we   [0:299];
    logic [8:0]  tr_wa   [0:299];
    logic [63:0] tr_wd   [0:299];
    logic        tr_done [0:299];

    cm_pack dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .read_base_sel (read_base_sel),
        .read_address  (read_address),
        .read_data     (read_data),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        read_data <= read_base_sel ? mem_m[read_address[1:0]] : mem_v[read_address[5:0]];

    // Reference: coefficient j -> v' word j/4 lane j%4, message bit j%64 of word j/64.
    task automatic build_expected();
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            logic [63:0] w;
            w = '0;
            for (int n = 0; n < 16; n++) begin
                int j, v, m, t;
                j = 16 * k + n;
                v = int'(mem_v[j / 4][16 * (j % 4) +: 10]);
                m = int'(mem_m[j / 64][j % 64]);
                t = ((v + 4 - 512 * m) % 1024 + 1024) % 1024;
                w[4 * n +: 4] = 4'(t / 64);
            end
            exp_q.push_back(w);
        end
    endtask

    // Pulses start, then records outputs at each negedge for cycles 1..ncyc.
    task automatic run_pass(input int ncyc, input int busy_at);
        start = 1'b1;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
            if (t == busy_at) start = 1'b1;
            else if (t == busy_at + 1) start = 1'b0;
            tr_sel[t]  = read_base_sel;
            tr_ra[t]   = read_address;
            tr_we[t]   = write_en;
            tr_wa[t]   = write_address;
            tr_wd[t]   = write_data;
            tr_done[t] = done;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({read_base_sel, read_address, write_address, write_en, done} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got sel=%0b ra=%0d wa=%0d we=%0b done=%0b, want all 0",
                     read_base_sel, read_address, write_address, write_en, done);
        end
    endtask

    task automatic test_patterns();
        logic [15:0] lanes [0:4];
        logic [63:0] msgs  [0:4];
        logic [63:0] wants [0:4];
        lanes = '{16'h0000, 16'h0000, 16'h03FF, 16'h003C, 16'hFC3C};
        msgs  = '{64'h0, {64{1'b1}}, 64'h0, 64'h0, 64'h0};
        wants = '{64'h0, 64'h8888_8888_8888_8888, 64'h0,
                  64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111};
        for (int p = 0; p < 5; p++) begin
            int nw, early_done;
            for (int i = 0; i < 64; i++) mem_v[i] = {4{lanes[p]}};
            for (int i = 0; i < 4; i++)  mem_m[i] = msgs[p];
            run_pass(217, 0);
            nw = 0;
            early_done = 0;
            for (int t = 1; t <= 217; t++) begin
                if (t <= 216 && tr_done[t] !== 1'b0) early_done++;
                if (tr_we[t] === 1'b1) begin
                    n_vec++;
                    if (tr_wd[t] !== wants[p] || tr_wa[t] !== 9'(nw)) begin
                        n_err++;
                        $display("FAIL pattern%0d_write: cycle %0d got addr=%0d data=%h, want addr=%0d data=%h",
                                 p, t, tr_wa[t], tr_wd[t], nw, wants[p]);
                    end
                    nw++;
                end
            end
            n_vec++;
            if (nw != 16) begin
                n_err++;
                $display("FAIL pattern%0d_write_count: got %0d, want 16", p, nw);
            end
            n_vec++;
            if (early_done != 0 || tr_done[217] !== 1'b1) begin
                n_err++;
                $display("FAIL pattern%0d_done_timing: early=%0d done@217=%0b, want 0 and 1",
                         p, early_done, tr_done[217]);
            end
        end
    endtask

    task automatic test_random();
        int nw;
        for (int i = 0; i < 64; i++) mem_v[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++)  mem_m[i] = {$urandom, $urandom};
        build_expected();
        run_pass(217, 50);
        nw = 0;
        for (int t = 1; t <= 216; t++) begin
            int w, p, q, g, r;
            w = (t - 1) / 54;
            p = (t - 1) % 54;
            if (p == 0) begin
                n_vec++;
                if (tr_sel[t] !== 1'b1 || tr_ra[t] !== 9'(w)) begin
                    n_err++;
                    $display("FAIL random_m_addr: cycle %0d got sel=%0b addr=%0d, want sel=1 addr=%0d",
                             t, tr_sel[t], tr_ra[t], w);
                end
            end else if (p >= 2) begin
                q = p - 2;
                g = q / 13;
                r = q % 13;
                if (r == 12) begin
                    n_vec++;
                    if (tr_we[t] !== 1'b1 || tr_wa[t] !== 9'(4 * w + g)) begin
                        n_err++;
                        $display("FAIL random_store: cycle %0d got we=%0b addr=%0d, want we=1 addr=%0d",
                                 t, tr_we[t], tr_wa[t], 4 * w + g);
                    end
                end else if (r % 3 == 0) begin
                    n_vec++;
                    if (tr_sel[t] !== 1'b0 || tr_ra[t] !== 9'(16 * w + 4 * g + r / 3) || tr_we[t] !== 1'b0) begin
                        n_err++;
                        $display("FAIL random_v_addr: cycle %0d got sel=%0b addr=%0d we=%0b, want sel=0 addr=%0d we=0",
                                 t, tr_sel[t], tr_ra[t], tr_we[t], 16 * w + 4 * g + r / 3);
                    end
                end
            end
            if (tr_we[t] === 1'b1) begin
                logic [63:0] e;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL random_extra_write: cycle %0d data=%h", t, tr_wd[t]);
                end else begin
                    e = exp_q.pop_front();
                    if (tr_wd[t] !== e) begin
                        n_err++;
                        $display("FAIL random_data: word %0d got %h, want %h", nw, tr_wd[t], e);
                    end
                end
                nw++;
            end
        end
        n_vec++;
        if (nw != 16 || tr_done[217] !== 1'b1 || tr_we[217] !== 1'b0) begin
            n_err++;
            $display("FAIL random_completion: writes=%0d done@217=%0b we@217=%0b, want 16 1 0",
                     nw, tr_done[217], tr_we[217]);
        end
    endtask

    task automatic test_back_to_back();
        int nw, early_done;
        repeat (5) @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || write_en !== 1'b0) begin
            n_err++;
            $display("FAIL done_hold: got done=%0b we=%0b, want 1 0", done, write_en);
        end
        build_expected();
        run_pass(217, 0);
        nw = 0;
        early_done = 0;
        for (int t = 1; t <= 217; t++) begin
            if (t <= 216 && tr_done[t] !== 1'b0) early_done++;
            if (tr_we[t] === 1'b1) begin
                logic [63:0] e;
                n_vec++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
                if (tr_wd[t] !== e || tr_wa[t] !== 9'(nw)) begin
                    n_err++;
                    $display("FAIL rerun_write: cycle %0d got addr=%0d data=%h, want addr=%0d data=%h",
                             t, tr_wa[t], tr_wd[t], nw, e);
                end
                nw++;
            end
        end
        n_vec++;
        if (nw != 16 || early_done != 0 || tr_done[217] !== 1'b1) begin
            n_err++;
            $display("FAIL rerun_completion: writes=%0d early_done=%0d done@217=%0b, want 16 0 1",
                     nw, early_done, tr_done[217]);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        start = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (t == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({read_base_sel, read_address, write_address, write_en, done} !== 21'd0) begin
            n_err++;
            $display("FAIL midpass_reset: got sel=%0b ra=%0d wa=%0d we=%0b done=%0b, want all 0",
                     read_base_sel, read_address, write_address, write_en, done);
        end
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (write_en !== 1'b0 || done !== 1'b0) bad++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (write_en !== 1'b0 || done !== 1'b0 || read_base_sel !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_idle: %0d cycles with activity, want 0", bad);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) mem_v[i] = '0;
        for (int i = 0; i < 4; i++)  mem_m[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_patterns();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
